dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage (word address/data/read/write) and a slow line-wide main memory. Hits complete in the same cycle. Misses assert stall_o, optionally write back a dirty victim, refill the line, then complete the held request. stall_o feeds the pipeline hazard logic, which freezes PC and all pipe registers while it is high.

---
 rtl/dcache_ctrl_if.sv | 28 ++
 rtl/dcache_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle for the direct-mapped data cache controller.
// The slave modport is the cache; the master modport drives the CPU and memory sides.
interface dcache_ctrl_if #(
    parameter int WORDS_PER_LINE = 4
);
    logic                          req_i;
    logic                          we_i;
    logic [31:0]                   addr_i;
    logic [31:0]                   wdata_i;
    logic [31:0]                   rdata_o;
    logic                          stall_o;
    logic                          mem_req_o;
    logic                          mem_we_o;
    logic [31:0]                   mem_addr_o;
    logic [32*WORDS_PER_LINE-1:0]  mem_wdata_o;
    logic [32*WORDS_PER_LINE-1:0]  mem_rdata_i;
    logic                          mem_ack_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, mem_rdata_i, mem_ack_i,
        output rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, mem_rdata_i, mem_ack_i,
        input  rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller with IDLE/WRITEBACK/ALLOCATE FSM.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl #(
    parameter int NUM_LINES      = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dcache_ctrl_if.slave      bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);
    localparam int OFF  = $clog2(WORDS_PER_LINE);
    localparam int IDX  = $clog2(NUM_LINES);
    localparam int TAGW = 30 - OFF - IDX;
    localparam int LW   = 32 * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [NUM_LINES-1:0]  r_valid;
    logic [NUM_LINES-1:0]  r_dirty;
    logic [TAGW-1:0]       r_tag  [NUM_LINES];
    logic [LW-1:0]         r_data [NUM_LINES];
    logic [TAGW-1:0]       r_req_tag;
    logic [IDX-1:0]        r_req_idx;

    logic [TAGW-1:0]       w_tag;
    logic [IDX-1:0]        w_idx;
    logic [OFF-1:0]        w_off;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_store_hit;
    logic                  w_fill;
    logic [31:0]           w_word;
    logic                  w_stall;
    logic [31:0]           w_rdata;
    logic                  w_mem_req;
    logic                  w_mem_we;
    logic [31:0]           w_mem_addr;
    logic [LW-1:0]         w_mem_wdata;

    assign w_tag       = bus.addr_i[31 -: TAGW];
    assign w_idx       = bus.addr_i[OFF+2 +: IDX];
    assign w_off       = bus.addr_i[2 +: OFF];
    assign w_hit       = bus.req_i & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_miss      = (r_state == IDLE) & bus.req_i & ~w_hit;
    assign w_store_hit = (r_state == IDLE) & w_hit & bus.we_i;
    assign w_fill      = (r_state == ALLOCATE) & bus.mem_ack_i;
    assign w_word      = r_data[w_idx][{w_off, 5'd0} +: 32];

    // Next-state and output decode; memory-side outputs depend only on state and latched request
    always_comb begin
        w_next      = r_state;
        w_stall     = 1'b0;
        w_rdata     = 32'd0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = 32'd0;
        w_mem_wdata = {LW{1'b0}};
        case (r_state)
            IDLE: begin
                if (bus.req_i) begin
                    if (w_hit) begin
                        if (bus.we_i) begin
                            w_rdata = 32'd0;
                        end else begin
                            w_rdata = w_word;
                        end
                    end else begin
                        w_stall = 1'b1;
                        if (r_valid[w_idx] & r_dirty[w_idx]) begin
                            w_next = WRITEBACK;
                        end else begin
                            w_next = ALLOCATE;
                        end
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            WRITEBACK: begin
                w_stall     = 1'b1;
                w_mem_req   = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = {r_tag[r_req_idx], r_req_idx, {(OFF+2){1'b0}}};
                w_mem_wdata = r_data[r_req_idx];
                if (bus.mem_ack_i) begin
                    w_next = ALLOCATE;
                end else begin
                    w_next = WRITEBACK;
                end
            end
            ALLOCATE: begin
                w_stall    = 1'b1;
                w_mem_req  = 1'b1;
                w_mem_addr = {r_req_tag, r_req_idx, {(OFF+2){1'b0}}};
                if (bus.mem_ack_i) begin
                    w_next = IDLE;
                end else begin
                    w_next = ALLOCATE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign bus.stall_o     = w_stall;
    assign bus.rdata_o     = w_rdata;
    assign bus.mem_req_o   = w_mem_req;
    assign bus.mem_we_o    = w_mem_we;
    assign bus.mem_addr_o  = w_mem_addr;
    assign bus.mem_wdata_o = w_mem_wdata;

    // State register and miss-address latch
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_req_tag <= {TAGW{1'b0}};
            r_req_idx <= {IDX{1'b0}};
        end else begin
            r_state <= w_next;
            if (w_miss) begin
                r_req_tag <= w_tag;
                r_req_idx <= w_idx;
            end
        end
    end

    // Valid and dirty bits; cleared by reset so in-flight refills are abandoned
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= {NUM_LINES{1'b0}};
            r_dirty <= {NUM_LINES{1'b0}};
        end else if (w_fill) begin
            r_valid[r_req_idx] <= 1'b1;
            r_dirty[r_req_idx] <= 1'b0;
        end else if (w_store_hit) begin
            r_dirty[w_idx] <= 1'b1;
        end
    end

    // Tag and data arrays; contents are meaningless while the valid bit is clear
    always_ff @(posedge clk_i) begin
        if (w_fill) begin
            r_tag[r_req_idx]  <= r_req_tag;
            r_data[r_req_idx] <= bus.mem_rdata_i;
        end else if (w_store_hit) begin
            r_data[w_idx][{w_off, 5'd0} +: 32] <= bus.wdata_i;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
    logic        r_refilled;

    // Access counters; the completing hit right after a refill belongs to the miss
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hit_cnt  <= 32'd0;
            r_miss_cnt <= 32'd0;
            r_refilled <= 1'b0;
        end else begin
            if (w_miss) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
            if ((r_state == IDLE) & w_hit & ~r_refilled) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_fill) begin
                r_refilled <= 1'b1;
            end else if (r_state == IDLE) begin
                r_refilled <= 1'b0;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed scoreboard bench for dcache_ctrl with a line-wide memory model and word-level reference.
module tb_dcache_ctrl;
    localparam int NL  = 32;
    localparam int WPL = 4;
    localparam int LW  = 32 * WPL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_ctrl_if #(.WORDS_PER_LINE(WPL)) cif ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dcache_ctrl #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (cif.slave)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int exp_hit  = 0;
    int exp_miss = 0;
    exp_t exp_q[$];
    logic [LW-1:0] mem_model [logic [31:0]];
    logic [31:0]   st_words  [logic [31:0]];

    function automatic logic [LW-1:0] init_line(input logic [31:0] la);
        logic [LW-1:0] l;
        if (la == 32'h0000_0040) begin
            l = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
        end else begin
            for (int i = 0; i < WPL; i++) l[i*32 +: 32] = 32'hA500_0000 ^ (la + 32'(i * 4));
        end
        return l;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [LW-1:0] l;
        logic [31:0]   wa;
        wa = {a[31:2], 2'b00};
        if (st_words.exists(wa)) return st_words[wa];
        l = init_line({wa[31:4], 4'h0});
        return l[wa[3:2]*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge where mem_req_o is first seen; acks after a fixed latency.
    task automatic serve(input bit exp_we, input logic [31:0] exp_addr, input logic [31:0] exp_w0,
                         input string tag);
        logic [31:0]   a;
        logic [LW-1:0] line;
        chk({tag, " we"}, LW'(cif.mem_we_o), LW'(exp_we));
        chk({tag, " addr"}, LW'(cif.mem_addr_o), LW'(exp_addr));
        if (exp_we) chk({tag, " wdata0"}, LW'(cif.mem_wdata_o[31:0]), LW'(exp_w0));
        a = cif.mem_addr_o;
        if (cif.mem_we_o) mem_model[a] = cif.mem_wdata_o;
        line = mem_model.exists(a) ? mem_model[a] : init_line(a);
        repeat (2) @(negedge clk);
        chk({tag, " addr stable"}, LW'(cif.mem_addr_o), LW'(exp_addr));
        cif.mem_ack_i   = 1'b1;
        cif.mem_rdata_i = line;
        chk({tag, " stall at ack"}, LW'(cif.stall_o), LW'(1'b1));
        @(negedge clk);
        cif.mem_ack_i   = 1'b0;
        cif.mem_rdata_i = {LW{1'b0}};
    endtask

    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input bit exp_wb, input logic [31:0] wb_addr, input bit exp_alloc,
                          input string tag);
        int guard;
        int ntx;
        bit miss;
        miss = exp_wb | exp_alloc;
        @(posedge clk);
        #1;
        cif.req_i   = 1'b1;
        cif.we_i    = we;
        cif.addr_i  = a;
        cif.wdata_i = wd;
        if (!we) exp_q.push_back('{tag, exp_word(a)});
        @(negedge clk);
        chk({tag, " stall on request"}, LW'(cif.stall_o), LW'(miss));
        guard = 0;
        ntx   = 0;
        while (cif.stall_o && guard < 200) begin
            @(negedge clk);
            guard++;
            if (cif.mem_req_o) begin
                if (exp_wb && ntx == 0) serve(1'b1, wb_addr, exp_word(wb_addr), {tag, " wb"});
                else serve(1'b0, {a[31:4], 4'h0}, 32'h0, {tag, " fill"});
                ntx++;
            end
        end
        chk({tag, " completes"}, LW'(guard < 200), LW'(1'b1));
        chk({tag, " transactions"}, LW'(ntx), LW'(int'(exp_wb) + int'(exp_alloc)));
        if (!we) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, " rdata"}, LW'(cif.rdata_o), LW'(e.val));
        end else begin
            st_words[{a[31:2], 2'b00}] = wd;
        end
        if (miss) exp_miss++;
        else exp_hit++;
    endtask

    initial begin
        cif.req_i       = 1'b0;
        cif.we_i        = 1'b0;
        cif.addr_i      = 32'd0;
        cif.wdata_i     = 32'd0;
        cif.mem_ack_i   = 1'b0;
        cif.mem_rdata_i = {LW{1'b0}};
        repeat (3) @(negedge clk);
        chk("reset stall", LW'(cif.stall_o), LW'(1'b0));
        chk("reset mem_req", LW'(cif.mem_req_o), LW'(1'b0));
        chk("reset rdata", LW'(cif.rdata_o), LW'(32'd0));
        rst = 1'b0;

        access(1'b0, 32'h0000_0040, 32'd0, 1'b0, 32'd0, 1'b1, "cold load 0x40");
        access(1'b0, 32'h0000_0044, 32'd0, 1'b0, 32'd0, 1'b0, "hit load 0x44");
        access(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0, "hit store 0x40");
        access(1'b0, 32'h0000_0840, 32'd0, 1'b1, 32'h0000_0040, 1'b1, "dirty conflict 0x840");
        access(1'b0, 32'h0000_0040, 32'd0, 1'b0, 32'd0, 1'b1, "clean conflict 0x40");
        access(1'b0, 32'h0000_0840, 32'd0, 1'b0, 32'd0, 1'b1, "clean conflict 0x840");
        access(1'b1, 32'h0000_0100, 32'h1234_5678, 1'b0, 32'd0, 1'b1, "store miss 0x100");
        access(1'b0, 32'h0000_0100, 32'd0, 1'b0, 32'd0, 1'b0, "load back 0x100");
        access(1'b0, 32'h0000_1100, 32'd0, 1'b1, 32'h0000_0100, 1'b1, "evict 0x100");

        // Reset in the middle of a refill, then a late ack
        @(posedge clk);
        #1;
        cif.req_i  = 1'b1;
        cif.we_i   = 1'b0;
        cif.addr_i = 32'h0000_0200;
        @(negedge clk);
        chk("rst-miss stall", LW'(cif.stall_o), LW'(1'b1));
        @(negedge clk);
        chk("rst-miss mem_req", LW'(cif.mem_req_o), LW'(1'b1));
        rst       = 1'b1;
        cif.req_i = 1'b0;
        @(negedge clk);
        chk("after rst stall", LW'(cif.stall_o), LW'(1'b0));
        chk("after rst mem_req", LW'(cif.mem_req_o), LW'(1'b0));
        chk("after rst rdata", LW'(cif.rdata_o), LW'(32'd0));
        rst             = 1'b0;
        exp_hit         = 0;
        exp_miss        = 0;
        cif.mem_ack_i   = 1'b1;
        cif.mem_rdata_i = init_line(32'h0000_0200);
        @(negedge clk);
        cif.mem_ack_i   = 1'b0;
        cif.mem_rdata_i = {LW{1'b0}};
        chk("late ack stall", LW'(cif.stall_o), LW'(1'b0));
        chk("late ack mem_req", LW'(cif.mem_req_o), LW'(1'b0));

        access(1'b0, 32'h0000_1100, 32'd0, 1'b0, 32'd0, 1'b1, "reload after rst");
        access(1'b0, 32'h0000_1104, 32'd0, 1'b0, 32'd0, 1'b0, "hit 0x1104");
        access(1'b0, 32'h0000_1108, 32'd0, 1'b0, 32'd0, 1'b0, "hit 0x1108");
        access(1'b0, 32'h0000_1900, 32'd0, 1'b0, 32'd0, 1'b1, "conflict 0x1900");
        access(1'b0, 32'h0000_1904, 32'd0, 1'b0, 32'd0, 1'b0, "hit 0x1904");
        @(posedge clk);
        #1;
        cif.req_i = 1'b0;
        @(negedge clk);
        chk("idle stall", LW'(cif.stall_o), LW'(1'b0));
        chk("idle rdata", LW'(cif.rdata_o), LW'(32'd0));
`ifdef DCACHE_STATS_EN
        chk("miss_cnt", LW'(miss_cnt), LW'(exp_miss));
        chk("hit_cnt", LW'(hit_cnt), LW'(exp_hit));
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
